mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1, memory cycles an access is held before read data is sampled (legal range 1..15).
REQ-002 SHALL have parameter MAX_DSTREAK, default 4, consecutive data grants allowed while if_req is pending before fetch is forced (legal range 1..15).
REQ-003 SHALL have port clk  in  1  clock, rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports if_req in 1 fetch request; if_addr in 32 fetch address; if_rdata out 32 fetched instruction; if_ready out 1 fetch complete pulse.
REQ-006 SHALL have ports d_req in 1 data request; d_we in 1 write enable; d_addr in 32 data address; d_wdata in 32 store data; d_rdata out 32 load data; d_ready out 1 data complete pulse.
REQ-007 SHALL have ports mem_addr out 32; mem_wdata out 32; mem_we out 1; mem_rdata in 32 (single shared memory port).
REQ-008 SHALL have ports busy out 1 (state != IDLE) and gnt_d out 1 (1 = current or last grant is data port).

Function
REQ-009 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; arbitration occurs only in IDLE.
REQ-010 SHALL, in IDLE with no request, remain in IDLE with mem_we=0.
REQ-011 SHALL, in IDLE with any request, grant data over fetch unless dstreak==MAX_DSTREAK and if_req=1, in which case fetch is granted.
REQ-012 SHALL, on grant, latch address, we (0 for fetch) and wdata of the winner into mem_addr/mem_we/mem_wdata, load cnt=LATENCY-1, enter ACCESS.
REQ-013 SHALL hold mem_addr/mem_wdata stable from grant edge through RESP; mem_we SHALL be 1 only in ACCESS for a data write.
REQ-014 SHALL decrement cnt each edge in ACCESS; at the edge with cnt==0, capture mem_rdata into the winner's rdata register and enter RESP.
REQ-015 SHALL assert the winner's ready for exactly the one RESP cycle; other ready stays 0; RESP always returns to IDLE.
REQ-016 SHALL give request-to-ready latency of LATENCY+1 edges (req sampled at edge 0, ready high after edge LATENCY+1); throughput one access per LATENCY+2 cycles.
REQ-017 SHALL keep if_rdata/d_rdata unchanged except at their own capture edge; write accesses also capture (value don't-care to requester).
REQ-018 SHALL increment dstreak (saturating at MAX_DSTREAK) on data grant when if_req=1, clear it on fetch grant, and hold it on data grant when if_req=0.
REQ-019 SHALL require requesters to hold req and operands stable until ready; a req seen in IDLE directly after RESP is a new request.
REQ-020 SHALL ignore request changes during ACCESS/RESP (no abort, no re-grant).

Reset
REQ-021 SHALL, on rst asserted at any time (including mid-ACCESS), immediately enter IDLE with mem_addr=0, mem_wdata=0, mem_we=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, busy=0, gnt_d=0, cnt=0, dstreak=0.
REQ-022 SHALL issue no ready pulse for an access interrupted by reset; first grant after rst release follows REQ-011.

Verification
REQ-023 Fetch only, LATENCY=1: if_req=1, if_addr=0x10, mem_rdata=0x00A00093 -> mem_addr=0x10 after edge 0, if_ready=1 and if_rdata=0x00A00093 after edge 2, mem_we never 1.
REQ-024 Simultaneous if_req and d_req (store 0xDEADBEEF to 0x100) -> data granted first, mem_we=1 one cycle, d_ready pulse, then fetch granted at next IDLE.
REQ-025 Starvation, MAX_DSTREAK=4: d_req and if_req held high continuously -> grant sequence D,D,D,D,F,D,D,D,D,F.
REQ-026 LATENCY=3 load from 0x200 -> ready exactly 4 edges after request, mem_addr stable 0x200 throughout, d_rdata equals mem_rdata at capture edge.
REQ-027 rst pulsed during ACCESS of a write -> mem_we=0 immediately, no d_ready, busy=0; new request after release serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port: IDLE -> ACCESS -> RESP, data wins unless fetch is starved.
// Request-to-ready is LATENCY+1 edges; requesters hold req/operands until their ready pulse.
module mem_port_arbiter #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        gnt_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [3:0] DS_MAX   = 4'(MAX_DSTREAK);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  dstreak_q, dstreak_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        gnt_d_q, gnt_d_d;
  logic        pick_fetch;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dstreak_d   = dstreak_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    gnt_d_d     = gnt_d_q;
    pick_fetch  = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Fetch only wins when data is idle or fetch has waited out a full data streak.
          pick_fetch  = if_req && (!d_req || (dstreak_q == DS_MAX));
          gnt_d_d     = !pick_fetch;
          mem_addr_d  = pick_fetch ? if_addr : d_addr;
          mem_wdata_d = pick_fetch ? 32'd0 : d_wdata;
          mem_we_d    = !pick_fetch && d_we;
          cnt_d       = CNT_INIT;
          state_d     = ACCESS;
          if (pick_fetch) begin
            dstreak_d = 4'd0;
          end else if (if_req && (dstreak_q != DS_MAX)) begin
            dstreak_d = dstreak_q + 4'd1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (gnt_d_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          mem_we_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        d_ready_d  = gnt_d_q;
        if_ready_d = !gnt_d_q;
        state_d    = IDLE;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dstreak_q   <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      gnt_d_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dstreak_q   <= dstreak_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      gnt_d_q     <= gnt_d_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign gnt_d     = gnt_d_q;
  assign busy      = (state_q != IDLE);

endmodule
